// File: rtl/eth_phy_10g_block_lock.sv
// 64b/66b block-lock and alignment: hunts for the bit offset that gives a steady
// sync header, then polices header errors per window and re-hunts on too many.
module eth_phy_10g_block_lock #(
    parameter int DATA_W    = 64,
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int BAD_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W+1:0]            in_data,
    input  logic                         in_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [1:0]                   out_hdr,
    output logic                         out_valid,
    output logic                         block_lock,
    output logic [$clog2(DATA_W+2)-1:0]  hdr_offset,
    output logic                         hdr_err
);

    localparam int W      = DATA_W + 2;
    localparam int OFF_W  = $clog2(W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_CNT + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);

    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(W - 1);
    localparam logic [OFF_W:0]    BASE_TOP  = (OFF_W + 1)'(W);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state_q;
    logic [W-1:0]      prevData_q;
    logic [OFF_W-1:0]  offset_q;
    logic [GOOD_W-1:0] goodCnt_q;
    logic [WIN_W-1:0]  winCnt_q;
    logic [BAD_W-1:0]  badCnt_q;
    logic [DATA_W-1:0] outData_q;
    logic [1:0]        outHdr_q;
    logic              outValid_q;
    logic              lock_q;
    logic              hdrErr_q;

    logic [2*W-1:0]    stream;
    logic [OFF_W:0]    base;
    logic [W-1:0]      window;
    logic              hdrValid;
    logic [OFF_W-1:0]  slipOffset_d;

    assign stream = {in_data, prevData_q};

    // Offset k selects a word that started k bits back inside the previous word.
    always_comb begin
        base         = BASE_TOP - {1'b0, offset_q};
        window       = stream[base +: W];
        hdrValid     = window[0] ^ window[1];
        slipOffset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            prevData_q <= '0;
            offset_q   <= '0;
            goodCnt_q  <= '0;
            winCnt_q   <= '0;
            badCnt_q   <= '0;
            outData_q  <= '0;
            outHdr_q   <= '0;
            outValid_q <= 1'b0;
            lock_q     <= 1'b0;
            hdrErr_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            hdrErr_q   <= 1'b0;
            if (in_valid) begin
                prevData_q <= in_data;
                outData_q  <= window[W-1:2];
                outHdr_q   <= window[1:0];
                outValid_q <= (state_q == LOCKED);
                hdrErr_q   <= !hdrValid;
                case (state_q)
                    SEARCH: begin
                        if (!hdrValid) begin
                            goodCnt_q <= '0;
                            offset_q  <= slipOffset_d;
                        end else if (goodCnt_q == GOOD_LAST) begin
                            state_q   <= LOCKED;
                            lock_q    <= 1'b1;
                            goodCnt_q <= '0;
                            winCnt_q  <= '0;
                            badCnt_q  <= '0;
                        end else begin
                            goodCnt_q <= goodCnt_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Losing lock wins over a window boundary on the same word.
                        if (!hdrValid && badCnt_q == BAD_LAST) begin
                            state_q   <= SEARCH;
                            lock_q    <= 1'b0;
                            offset_q  <= slipOffset_d;
                            goodCnt_q <= '0;
                            winCnt_q  <= '0;
                            badCnt_q  <= '0;
                        end else if (winCnt_q == WIN_LAST) begin
                            winCnt_q <= '0;
                            badCnt_q <= '0;
                        end else begin
                            winCnt_q <= winCnt_q + 1'b1;
                            badCnt_q <= badCnt_q + BAD_W'(!hdrValid);
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign out_data   = outData_q;
    assign out_hdr    = outHdr_q;
    assign out_valid  = outValid_q;
    assign block_lock = lock_q;
    assign hdr_offset = offset_q;
    assign hdr_err    = hdrErr_q;

endmodule
